key_expander: RTL and testbench

AES-128 key schedule block. Takes a 128-bit cipher key and produces all 11 round keys (round 0 through round 10) in parallel, per FIPS-197. Sits beside the AES round datapath and supplies every round key at once. All outputs are registered.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_sbox.sv | 78 +++++++
 rtl/key_expander.sv | 81 ++++++++
 tb/tb_key_expander.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule types and constants
package aes_pkg;

    localparam int NR = 10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;

    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    always_comb begin
        out_byte = 8'h00;
        case (in_byte)
            8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b;
            8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
            8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b;
            8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
            8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d;
            8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
            8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf;
            8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
            8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26;
            8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
            8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1;
            8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
            8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3;
            8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
            8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2;
            8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
            8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a;
            8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
            8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3;
            8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
            8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed;
            8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
            8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39;
            8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
            8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb;
            8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
            8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f;
            8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
            8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f;
            8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
            8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21;
            8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
            8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec;
            8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
            8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d;
            8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
            8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc;
            8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
            8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14;
            8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
            8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a;
            8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
            8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62;
            8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
            8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d;
            8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
            8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea;
            8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
            8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e;
            8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
            8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f;
            8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
            8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66;
            8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
            8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9;
            8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
            8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11;
            8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
            8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9;
            8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
            8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d;
            8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
            8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f;
            8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
            default: out_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/key_expander.sv
// rtl/key_expander.sv - AES-128 key schedule, all 11 round keys registered in parallel
module key_expander
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] cipher_key,
    output logic [127:0] expanded_key_1,
    output logic [127:0] expanded_key_2,
    output logic [127:0] expanded_key_3,
    output logic [127:0] expanded_key_4,
    output logic [127:0] expanded_key_5,
    output logic [127:0] expanded_key_6,
    output logic [127:0] expanded_key_7,
    output logic [127:0] expanded_key_8,
    output logic [127:0] expanded_key_9,
    output logic [127:0] expanded_key_10,
    output logic [127:0] expanded_key_11
);

    round_key_t key_d [NR+1];
    round_key_t key_q [NR+1];

    assign key_d[0] = cipher_key;

    // Each round block chains off the previous block's key so no single
    // variable feeds back into itself.
    for (genvar r = 1; r <= NR; r++) begin : gen_round
        round_key_t prev;
        round_key_t rk;
        word_t      rot;
        word_t      sub;
        word_t      temp;
        word_t      w0, w1, w2, w3;

        if (r == 1) begin : gen_first
            assign prev = cipher_key;
        end else begin : gen_chain
            assign prev = gen_round[r-1].rk;
        end

        assign rot = rot_word(prev[31:0]);

        for (genvar b = 0; b < 4; b++) begin : gen_sub
            aes_sbox u_sbox (
                .in_byte  (rot[8*b +: 8]),
                .out_byte (sub[8*b +: 8])
            );
        end

        assign temp = sub ^ {RCON[r-1], 24'h0};
        assign w0   = prev[127:96] ^ temp;
        assign w1   = prev[95:64]  ^ w0;
        assign w2   = prev[63:32]  ^ w1;
        assign w3   = prev[31:0]   ^ w2;
        assign rk   = {w0, w1, w2, w3};

        assign key_d[r] = rk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r <= NR; r++) key_q[r] <= '0;
        end else begin
            for (int r = 0; r <= NR; r++) key_q[r] <= key_d[r];
        end
    end

    assign expanded_key_1  = key_q[0];
    assign expanded_key_2  = key_q[1];
    assign expanded_key_3  = key_q[2];
    assign expanded_key_4  = key_q[3];
    assign expanded_key_5  = key_q[4];
    assign expanded_key_6  = key_q[5];
    assign expanded_key_7  = key_q[6];
    assign expanded_key_8  = key_q[7];
    assign expanded_key_9  = key_q[8];
    assign expanded_key_10 = key_q[9];
    assign expanded_key_11 = key_q[10];

endmodule

// File: tb/tb_key_expander.sv
// tb/tb_key_expander.sv - self-checking bench for key_expander
module tb_key_expander;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ONES_KEY = {128{1'b1}};

    logic         clk;
    logic         rst_n;
    logic [127:0] cipher_key;
    logic [127:0] ek1, ek2, ek3, ek4, ek5, ek6, ek7, ek8, ek9, ek10, ek11;
    logic [127:0] obs [11];

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_ref [256];
    logic [127:0] exp_rk [11];

    key_expander dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cipher_key      (cipher_key),
        .expanded_key_1  (ek1),
        .expanded_key_2  (ek2),
        .expanded_key_3  (ek3),
        .expanded_key_4  (ek4),
        .expanded_key_5  (ek5),
        .expanded_key_6  (ek6),
        .expanded_key_7  (ek7),
        .expanded_key_8  (ek8),
        .expanded_key_9  (ek9),
        .expanded_key_10 (ek10),
        .expanded_key_11 (ek11)
    );

    always_comb begin
        obs[0] = ek1;  obs[1] = ek2;  obs[2]  = ek3; obs[3] = ek4;
        obs[4] = ek5;  obs[5] = ek6;  obs[6]  = ek7; obs[7] = ek8;
        obs[8] = ek9;  obs[9] = ek10; obs[10] = ek11;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gf_mul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        cipher_key = FIPS_KEY;
        repeat (3) @(posedge clk);
        #1;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== 128'h0) begin
                errors++;
                $display("FAIL reset_zero rk%0d got=%h want=%h", r, obs[r], 128'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_expand(FIPS_KEY);
        @(posedge clk);
        #1;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL reset_release rk%0d got=%h want=%h", r, obs[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_known_vectors();
        @(negedge clk);
        cipher_key = 128'h0;
        @(posedge clk);
        #1;
        checks++;
        if (ek1 !== 128'h0) begin
            errors++; $display("FAIL zero_ek1 got=%h want=%h", ek1, 128'h0);
        end
        checks++;
        if (ek2 !== 128'h62636363626363636263636362636363) begin
            errors++; $display("FAIL zero_ek2 got=%h want=62636363626363636263636362636363", ek2);
        end
        checks++;
        if (ek3 !== 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa) begin
            errors++; $display("FAIL zero_ek3 got=%h want=9b9898c9f9fbfbaa9b9898c9f9fbfbaa", ek3);
        end
        checks++;
        if (ek11 !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++; $display("FAIL zero_ek11 got=%h want=b4ef5bcb3e92e21123e951cf6f8f188e", ek11);
        end

        @(negedge clk);
        cipher_key = FIPS_KEY;
        @(posedge clk);
        #1;
        checks++;
        if (ek1 !== FIPS_KEY) begin
            errors++; $display("FAIL fips_ek1 got=%h want=%h", ek1, FIPS_KEY);
        end
        checks++;
        if (ek2 !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++; $display("FAIL fips_ek2 got=%h want=a0fafe1788542cb123a339392a6c7605", ek2);
        end
        checks++;
        if (ek11 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++; $display("FAIL fips_ek11 got=%h want=d014f9a8c9ee2589e13f0cc8b6630ca6", ek11);
        end

        @(negedge clk);
        cipher_key = ONES_KEY;
        model_expand(ONES_KEY);
        @(posedge clk);
        #1;
        checks++;
        if (ek2 !== 128'he8e9e9e917161616e8e9e9e917161616) begin
            errors++; $display("FAIL ones_ek2 got=%h want=e8e9e9e917161616e8e9e9e917161616", ek2);
        end
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL ones_model rk%0d got=%h want=%h", r, obs[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cipher_key = 128'h0;
        @(posedge clk);
        #1;
        cipher_key = FIPS_KEY;
        model_expand(128'h0);
        @(negedge clk);
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL b2b_hold_zero rk%0d got=%h want=%h", r, obs[r], exp_rk[r]);
            end
        end
        model_expand(FIPS_KEY);
        @(posedge clk);
        #1;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL b2b_fips rk%0d got=%h want=%h", r, obs[r], exp_rk[r]);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [127:0] k;
        for (int n = 0; n < 40; n++) begin
            k = rand_key();
            @(negedge clk);
            cipher_key = k;
            model_expand(k);
            @(posedge clk);
            #1;
            for (int r = 0; r < 11; r++) begin
                checks++;
                if (obs[r] !== exp_rk[r]) begin
                    errors++;
                    $display("FAIL random key=%h rk%0d got=%h want=%h", k, r, obs[r], exp_rk[r]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] k;
        k = rand_key();
        @(negedge clk);
        cipher_key = k;
        model_expand(k);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== 128'h0) begin
                errors++;
                $display("FAIL async_clear rk%0d got=%h want=%h", r, obs[r], 128'h0);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (ek11 !== 128'h0) begin
            errors++; $display("FAIL async_hold ek11 got=%h want=%h", ek11, 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ek1 !== 128'h0) begin
            errors++; $display("FAIL async_release_pre ek1 got=%h want=%h", ek1, 128'h0);
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < 11; r++) begin
            checks++;
            if (obs[r] !== exp_rk[r]) begin
                errors++;
                $display("FAIL async_reload rk%0d got=%h want=%h", r, obs[r], exp_rk[r]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cipher_key = FIPS_KEY;
        build_sbox();
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_random_stream();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
